// File: rtl/diff_scan.sv
// diff_scan: locates the lowest bit where rs and rt differ by scanning
// x = rs ^ rt one bit per clock, and reports it as a one-hot vector.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - asynchronous active-low reset
//   start   - begin a scan (accepted only in IDLE and only when flush=0)
//   flush   - abort an in-progress scan (no done pulse, clears results)
//   rs, rt  - operands, latched as rs^rt when a start is accepted
//   busy    - high while scanning
//   done    - single-cycle completion pulse
//   onehot  - lowest differing bit as one-hot, zero when the operands are equal
//   found   - high when onehot is non-zero
//
// Build option: DIFF_SCAN_ZERO_SKIP_EN -- when defined, equal operands go
// straight to DONE at the accepting edge instead of scanning all WIDTH bits.
module diff_scan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] onehot,
  output logic             found
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x;
  logic [CW-1:0]    cnt;
  logic             accept, hit, last, skip;

  always_comb begin
    state_nxt = state;
    accept    = (state == IDLE) && start && !flush;
    hit       = x[cnt];
    last      = (cnt == CW'(WIDTH-1));
`ifdef DIFF_SCAN_ZERO_SKIP_EN
    skip      = ((rs ^ rt) == '0);
`else
    skip      = 1'b0;
`endif
    case (state)
      IDLE: if (accept) state_nxt = skip ? DONE : SCAN;
      // flush wins over completion even on the final bit
      SCAN: if (flush) state_nxt = IDLE;
            else if (hit || last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath. onehot/found are only written on accept, hit or flush, so
  // they hold through DONE and IDLE until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x      <= '0;
      cnt    <= '0;
      onehot <= '0;
      found  <= 1'b0;
    end else if (accept) begin
      x      <= rs ^ rt;
      cnt    <= '0;
      onehot <= '0;
      found  <= 1'b0;
    end else if (state == SCAN) begin
      if (flush) begin
        onehot <= '0;
        found  <= 1'b0;
      end else if (hit) begin
        onehot <= WIDTH'(1) << cnt;
        found  <= 1'b1;
      end else if (!last) begin
        // terminal bit checked first so cnt never wraps
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_diff_scan.sv
module tb_diff_scan;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic         busy, done, found;
  logic [W-1:0] onehot;

  diff_scan #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .rs(rs), .rt(rt), .busy(busy), .done(done),
    .onehot(onehot), .found(found)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] onehot;
    logic         found;
    int           cyc;
  } exp_t;

  exp_t sb[$];

`ifdef DIFF_SCAN_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: position of lowest differing bit, -1 if the operands match.
  function automatic int lowest_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++)
      if (a[i] != b[i]) return i;
    return -1;
  endfunction

  function automatic int scan_lat(input int k);
    if (k >= 0) return k + 1;
    return ZSKIP ? 0 : W;
  endfunction

  // Monitor: pops an expectation on every done pulse, plus invariants.
  always @(negedge clk) begin
    if (rst) begin
      chk("found_vs_onehot", W'(found), W'(onehot != '0));
      chk("onehot_popcount", W'($countones(onehot) <= 1), W'(1));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", W'(done), W'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_onehot", onehot, e.onehot);
          chk("done_found", W'(found), W'(e.found));
          chk("done_cycle", W'(cyc), W'(e.cyc));
          chk("busy_in_done", W'(busy), W'(0));
        end
      end
    end
  end

  // One scan. flush_at / restart_at give the edge index (1-based after the
  // start-sampling edge 0) at which flush or an ignored start is driven; 0 = none.
  task automatic do_scan(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int flush_at, input int restart_at);
    int k, lat, e0;
    logic [W-1:0] eoh;
    logic         efd;
    k   = lowest_diff(a, b);
    lat = scan_lat(k);
    eoh = (k >= 0) ? (W'(1) << k) : '0;
    efd = (k >= 0);
    @(negedge clk);
    rs = a; rt = b; start = 1'b1; flush = 1'b0;
    e0 = cyc + 1;
    if (flush_at == 0) begin
      exp_t e;
      e.onehot = eoh; e.found = efd; e.cyc = e0 + lat;
      sb.push_back(e);
    end
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      start = (j == restart_at);
      if (start) begin rs = $urandom; rt = $urandom; end
      flush = (j == flush_at);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_busy", W'(busy), W'(0));
    chk("idle_done", W'(done), W'(0));
    if (flush_at != 0) begin
      eoh = '0; efd = 1'b0;
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("hold_onehot", onehot, eoh);
    chk("hold_found", W'(found), W'(efd));
  endtask

  initial begin
    int k, lat, fa, ra, mode;
    logic [W-1:0] a, x;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_onehot", onehot, '0);
    chk("rst_found", W'(found), W'(0));
    rst = 1'b1;

    // first start right after reset release, then directed cases
    do_scan(32'h0000_00F0, 32'h0000_0010, 0, 0);
    do_scan(32'h8000_0000, 32'h0, 0, 0);

    // async reset in IDLE clears held result immediately
    #2 rst = 1'b0;
    #1 chk("async_rst_onehot", onehot, '0);
    chk("async_rst_found", W'(found), W'(0));
    @(negedge clk) rst = 1'b1;

    do_scan(32'h1234_5678, 32'h1234_5678, 0, 0);
    do_scan(32'h0001_0000, 32'h0, 10, 5);

    // reset mid-scan: outputs drop at once, no done afterwards
    @(negedge clk);
    rs = 32'h0001_0000; rt = '0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midscan_rst_busy", W'(busy), W'(0));
    chk("midscan_rst_done", W'(done), W'(0));
    chk("midscan_rst_onehot", onehot, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    do_scan(32'h1, 32'h0, 0, 0);

    // randomized scans
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: x = $urandom;
        1: x = W'(1) << $urandom_range(0, W-1);
        2: x = '0;
        default: x = $urandom << $urandom_range(0, W-1);
      endcase
      k = lowest_diff(a, a ^ x);
      lat = scan_lat(k);
      fa = 0; ra = 0;
      if (lat >= 1 && $urandom_range(0, 3) == 0) fa = $urandom_range(1, lat);
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom_range(1, lat + 1);
        if (fa != 0 && ra > fa) ra = fa;
      end
      do_scan(a, a ^ x, fa, ra);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", W'(sb.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diff_scan.md
DIFF_SCAN -- requirements
Module: diff_scan

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and one-hot vector width; legal values are 8, 16 and 32.
REQ-002 The block SHALL have port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, in, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, in, 1: request to begin a scan, sampled on a rising clk edge.
REQ-005 The block SHALL have port flush, in, 1: synchronous abort of an in-progress scan.
REQ-006 The block SHALL have port rs, in, WIDTH: first operand.
REQ-007 The block SHALL have port rt, in, WIDTH: second operand.
REQ-008 The block SHALL have port busy, out, 1: high while in SCAN.
REQ-009 The block SHALL have port done, out, 1: single-cycle completion pulse.
REQ-010 The block SHALL have port onehot, out, WIDTH: lowest differing bit of rs and rt as a one-hot vector, or all-zero when none; this drives the downstream one-hot-to-index encoder.
REQ-011 The block SHALL have port found, out, 1: high when onehot is non-zero.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE with start=1 and flush=0, the block SHALL, at the edge:
- latch x = rs XOR rt;
- clear the bit counter cnt (log2(WIDTH) bits) to 0;
- clear onehot and found;
- enter SCAN.
REQ-014 In IDLE with start=0, or with start=1 and flush=1, the block SHALL remain in IDLE.
REQ-015 A start in SCAN or DONE SHALL be ignored; the operands are not relatched.
REQ-016 In SCAN, at each edge, the block SHALL examine x[cnt]:
- if x[cnt]=1: set onehot = 1 shifted left by cnt, set found=1, enter DONE;
- else if cnt = WIDTH-1: leave onehot=0, set found=0, enter DONE;
- otherwise: increment cnt and stay in SCAN.
REQ-017 Latency SHALL be as follows: with the lowest set bit of x at position k, done SHALL be high in the cycle following edge k+1, counted from the start-sampling edge as edge 0.
REQ-018 DONE SHALL last exactly one cycle, with done=1 only in that cycle, and SHALL then return to IDLE.
REQ-019 onehot and found SHALL hold their values until the next accepted start or reset.
REQ-020 flush=1 in SCAN SHALL force IDLE at the next edge, with no done pulse, and SHALL clear onehot and found.
REQ-021 flush in IDLE or DONE SHALL have no effect other than blocking start.
REQ-022 cnt SHALL never wrap; the terminal condition at WIDTH-1 SHALL take precedence over increment.
REQ-023 onehot SHALL have at most one bit set at all times.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force:
- state to IDLE;
- cnt=0 and x=0;
- busy=0, done=0, found=0;
- onehot=0.
REQ-025 Reset asserted mid-scan SHALL discard the scan; no done pulse SHALL follow its release.
REQ-026 After rst deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Configuration
REQ-027 The macro DIFF_SCAN_ZERO_SKIP_EN SHALL control handling of equal operands (x=0):
- when defined, an accepted start with rs XOR rt = 0 SHALL go directly to DONE at edge 0, so done is high in the cycle after edge 0, with onehot=0 and found=0;
- when undefined, equal operands SHALL scan all WIDTH bits, so done is high after edge WIDTH, with onehot=0 and found=0.
REQ-028 Non-zero operand behaviour SHALL be identical with and without DIFF_SCAN_ZERO_SKIP_EN.

Verification (WIDTH=32)
REQ-029 rs=0x0000_00F0, rt=0x0000_0010, start for one cycle -> busy for 6 cycles; done pulses once after edge 6; onehot=0x0000_0020; found=1.
REQ-030 rs=0x8000_0000, rt=0 -> done after edge 32; onehot=0x8000_0000; found=1; onehot holds through IDLE.
REQ-031 rs=rt=0x1234_5678 -> with DIFF_SCAN_ZERO_SKIP_EN: done after edge 0; without it: done after edge 32; both cases give onehot=0 and found=0.
REQ-032 rs=0x0001_0000, rt=0; a second start with different operands at cycle 5; flush at cycle 10 -> second start ignored; no done pulse; back in IDLE with onehot=0.
REQ-033 rst=0 asserted asynchronously mid-scan at cycle 3, released at cycle 6 -> outputs zero immediately, no done pulse; a new start with rs=1, rt=0 -> done after edge 1 with onehot=0x0000_0001.
